// File: rtl/voice_allocator_if.sv
// Bundle between the keyboard decoder / tone bank and the voice allocator.
//   pressed_key  : level vector, bit k high while key k is held
//   voice_active : bit v high while voice v sounds a key
//   voice_key    : key index of voice v in [v*KEY_W +: KEY_W]
//   note_on      : one-cycle retrigger pulse per voice
//   steal        : one-cycle pulse when an active voice was taken over
//   busy         : allocator is applying an event or has edges pending
// master = keyboard/tone-bank side, slave = allocator.
interface voice_allocator_if #(
  parameter int NUM_KEYS   = 48,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 6
);
  logic [NUM_KEYS-1:0]         pressed_key;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]       note_on;
  logic                        steal;
  logic                        busy;

  modport master (
    output pressed_key,
    input  voice_active, voice_key, note_on, steal, busy
  );

  modport slave (
    input  pressed_key,
    output voice_active, voice_key, note_on, steal, busy
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler. Detects key press/release edges against the
// last serviced key state, services one edge per two cycles (IDLE selects,
// APPLY executes), assigns presses to the lowest free voice or steals the
// least-recently-assigned one, and frees a voice when its key is released.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : voice_allocator_if slave modport (see interface header)
module voice_allocator #(
  parameter int NUM_KEYS   = 48,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 6
) (
  input logic             clk,
  input logic             reset,
  voice_allocator_if.slave bus
);

  localparam int VIDX_W = $clog2(NUM_VOICES);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] APPLY = 1'b1;

  logic [0:0]            state;
  logic [NUM_KEYS-1:0]   seen;
  logic [KEY_W-1:0]      ev_key;
  logic                  ev_press;
  logic [NUM_VOICES-1:0] active;
  logic [KEY_W-1:0]      vkey [NUM_VOICES];
  logic [VIDX_W-1:0]     age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] note_on;
  logic                  steal;

  logic [NUM_KEYS-1:0]   rel;
  logic [NUM_KEYS-1:0]   prs;
  logic [KEY_W-1:0]      sel_key;
  logic                  sel_press;
  logic                  have_free;
  logic [VIDX_W-1:0]     tgt;

  // Event selection: releases before presses, lowest key index within a
  // class. Scanning downward leaves the lowest set index in sel_key.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sel_key   = '0;
    rel       = seen & ~bus.pressed_key;
    prs       = bus.pressed_key & ~seen;
    sel_press = ~(|rel);
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (sel_press ? prs[k] : rel[k]) sel_key = KEY_W'(k);
    end
  end

  // Target voice for a press: lowest inactive voice, otherwise the oldest.
  always_comb begin
    tgt       = '0;
    have_free = ~(&active);
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) tgt = VIDX_W'(v);
    end
    if (!have_free) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (age[v] == VIDX_W'(NUM_VOICES - 1)) tgt = VIDX_W'(v);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      seen     <= '0;
      ev_key   <= '0;
      ev_press <= 1'b0;
      active   <= '0;
      note_on  <= '0;
      steal    <= 1'b0;
      // NOTE: the per-voice arrays are reset explicitly: age must start as
      // a valid permutation and voice_key must read 0 out of reset.
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey[v] <= '0;
        age[v]  <= VIDX_W'(v);
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read
      // in this block sees the pre-edge value (age compare below relies on it).
      note_on <= '0;
      steal   <= 1'b0;
      case (state)
        IDLE: begin
          if (|(bus.pressed_key ^ seen)) begin
            ev_key   <= sel_key;
            ev_press <= sel_press;
            state    <= APPLY;
          end
        end
        default: begin
          seen[ev_key] <= ev_press;
          state        <= IDLE;
          if (!ev_press) begin
            // A stolen key matches no voice; only seen changes.
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (active[v] && vkey[v] == ev_key) active[v] <= 1'b0;
            end
          end else begin
            active[tgt]  <= 1'b1;
            vkey[tgt]    <= ev_key;
            note_on[tgt] <= 1'b1;
            steal        <= ~have_free;
            // Everything newer than the target ages by one; target becomes newest.
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (age[v] < age[tgt]) age[v] <= age[v] + 1'b1;
            end
            age[tgt] <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      bus.voice_key[v*KEY_W +: KEY_W] = vkey[v];
    end
  end

  assign bus.voice_active = active;
  assign bus.note_on      = note_on;
  assign bus.steal        = steal;
  assign bus.busy         = reset & ((state == APPLY) | (|(bus.pressed_key ^ seen)));

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NK = 48;
  localparam int NV = 4;
  localparam int KW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  voice_allocator_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) bus ();

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: event-level behaviour with an explicit LRU order list
  // (front = least recently assigned voice).
  bit          m_seen [NK];
  bit          m_act  [NV];
  int          m_key  [NV];
  int          lru    [$];
  bit          m_apply;
  int          ev_k;
  bit          ev_p;
  logic [NV-1:0] m_non;
  bit          m_steal;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (m_seen[k]) m_seen[k] = 1'b0;
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 1'b0;
      m_key[v] = 0;
    end
    lru.delete();
    for (int v = NV - 1; v >= 0; v--) lru.push_back(v);
    m_apply = 1'b0;
    m_non   = '0;
    m_steal = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    int tv;
    m_non   = '0;
    m_steal = 1'b0;
    if (!m_apply) begin
      found = 1'b0;
      for (int k = 0; k < NK; k++)
        if (!found && m_seen[k] && !bus.pressed_key[k]) begin ev_k = k; ev_p = 1'b0; found = 1'b1; end
      for (int k = 0; k < NK; k++)
        if (!found && !m_seen[k] && bus.pressed_key[k]) begin ev_k = k; ev_p = 1'b1; found = 1'b1; end
      m_apply = found;
    end else begin
      m_apply = 1'b0;
      m_seen[ev_k] = ev_p;
      if (!ev_p) begin
        for (int v = 0; v < NV; v++)
          if (m_act[v] && m_key[v] == ev_k) m_act[v] = 1'b0;
      end else begin
        tv = -1;
        for (int v = 0; v < NV; v++) if (tv < 0 && !m_act[v]) tv = v;
        if (tv < 0) begin
          tv = lru[0];
          m_steal = 1'b1;
        end
        for (int i = 0; i < lru.size(); i++)
          if (lru[i] == tv) begin lru.delete(i); break; end
        lru.push_back(tv);
        m_act[tv] = 1'b1;
        m_key[tv] = ev_k;
        m_non[tv] = 1'b1;
      end
    end
  endtask

  function automatic logic model_busy();
    logic d = 1'b0;
    for (int k = 0; k < NK; k++) if (m_seen[k] != bus.pressed_key[k]) d = 1'b1;
    return rst_n & (m_apply | d);
  endfunction

  task automatic compare_all(string tag);
    logic [NV-1:0]    e_act;
    logic [NV*KW-1:0] e_key;
    logic [NV*KW-1:0] o_key;
    e_key = '0;
    o_key = '0;
    for (int v = 0; v < NV; v++) begin
      e_act[v] = m_act[v];
      if (m_act[v]) begin
        e_key[v*KW +: KW] = KW'(m_key[v]);
        o_key[v*KW +: KW] = bus.voice_key[v*KW +: KW];
      end
    end
    check({tag, ".active"}, 64'(bus.voice_active), 64'(e_act));
    check({tag, ".key"},    64'(o_key),            64'(e_key));
    check({tag, ".note_on"},64'(bus.note_on),      64'(m_non));
    check({tag, ".steal"},  64'(bus.steal),        64'(m_steal));
    check({tag, ".busy"},   64'(bus.busy),         64'(model_busy()));
  endtask

  task automatic tick(string tag = "tick");
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int busy_cnt;
  int k;

  initial begin
    bus.pressed_key = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    check("rst.active",  64'(bus.voice_active), 64'h0);
    check("rst.key",     64'(bus.voice_key),    64'h0);
    check("rst.note_on", 64'(bus.note_on),      64'h0);
    check("rst.steal",   64'(bus.steal),        64'h0);
    check("rst.busy",    64'(bus.busy),         64'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // Single press / release of key 12
    bus.pressed_key[12] = 1'b1;
    #1 check("p12.busy_now", 64'(bus.busy), 64'h1);
    ticks(2);
    check("p12.active",  64'(bus.voice_active),   64'h1);
    check("p12.key0",    64'(bus.voice_key[5:0]), 64'd12);
    check("p12.note_on", 64'(bus.note_on),        64'h1);
    check("p12.steal",   64'(bus.steal),          64'h0);
    ticks(2);
    bus.pressed_key[12] = 1'b0;
    ticks(2);
    check("r12.active",  64'(bus.voice_active), 64'h0);
    check("r12.note_on", 64'(bus.note_on),      64'h0);
    ticks(2);

    // Three simultaneous presses
    bus.pressed_key[3] = 1'b1;
    bus.pressed_key[7] = 1'b1;
    bus.pressed_key[20] = 1'b1;
    #1 busy_cnt = int'(bus.busy);
    for (int i = 0; i < 10; i++) begin
      tick("multi");
      busy_cnt += int'(bus.busy);
      if (i == 1) check("multi.k3_v0", 64'(bus.note_on), 64'h1);
      if (i == 3) check("multi.k7_v1", 64'(bus.note_on), 64'h2);
      if (i == 5) check("multi.k20_v2", 64'(bus.note_on), 64'h4);
    end
    check("multi.busy_cycles", 64'(busy_cnt), 64'd6);
    check("multi.key2", 64'(bus.voice_key[17:12]), 64'd20);
    bus.pressed_key = '0;
    ticks(10);

    // Sequential 1..4 then steals by 5 and 6
    for (int kk = 1; kk <= 4; kk++) begin
      bus.pressed_key[kk] = 1'b1;
      ticks(3);
    end
    check("full.active", 64'(bus.voice_active), 64'hF);
    bus.pressed_key[5] = 1'b1;
    ticks(2);
    check("steal5.steal",   64'(bus.steal),          64'h1);
    check("steal5.note_on", 64'(bus.note_on),        64'h1);
    check("steal5.key0",    64'(bus.voice_key[5:0]), 64'd5);
    ticks(1);
    bus.pressed_key[6] = 1'b1;
    ticks(2);
    check("steal6.steal",   64'(bus.steal),           64'h1);
    check("steal6.note_on", 64'(bus.note_on),         64'h2);
    check("steal6.key1",    64'(bus.voice_key[11:6]), 64'd6);
    ticks(1);

    // Release a stolen key: nothing changes
    bus.pressed_key[1] = 1'b0;
    ticks(2);
    check("rel1.busy",    64'(bus.busy),         64'h0);
    check("rel1.active",  64'(bus.voice_active), 64'hF);
    check("rel1.note_on", 64'(bus.note_on),      64'h0);
    bus.pressed_key = '0;
    ticks(16);

    // Full voices: press 9 and release 2 together
    for (int kk = 1; kk <= 4; kk++) begin
      bus.pressed_key[kk] = 1'b1;
      ticks(3);
    end
    bus.pressed_key[9] = 1'b1;
    bus.pressed_key[2] = 1'b0;
    ticks(2);
    check("r2p9.freed", 64'(bus.voice_active), 64'hD);
    ticks(2);
    check("r2p9.note_on", 64'(bus.note_on),           64'h2);
    check("r2p9.steal",   64'(bus.steal),             64'h0);
    check("r2p9.key1",    64'(bus.voice_key[11:6]),   64'd9);
    bus.pressed_key = '0;
    ticks(16);

    // Reset during APPLY with keys 5 and 10 held
    bus.pressed_key[5] = 1'b1;
    bus.pressed_key[10] = 1'b1;
    ticks(3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.active",  64'(bus.voice_active), 64'h0);
    check("midrst.key",     64'(bus.voice_key),    64'h0);
    check("midrst.note_on", 64'(bus.note_on),      64'h0);
    check("midrst.busy",    64'(bus.busy),         64'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    check("midrst.k5_v0", 64'(bus.note_on), 64'h1);
    ticks(2);
    check("midrst.k10_v1", 64'(bus.note_on),          64'h2);
    check("midrst.key1",   64'(bus.voice_key[11:6]), 64'd10);
    ticks(2);

    // Randomised key activity over keys 0..11 and the top keys 46, 47
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(0, 13));
        if (k > 11) k = k + 34;
        bus.pressed_key[k] = ~bus.pressed_key[k];
      end
      tick("rand");
    end
    bus.pressed_key = '0;
    ticks(40);
    check("end.active", 64'(bus.voice_active), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the keyboard decoder's 48-bit `pressed_key` vector and a bank of `NUM_VOICES` tone generators. It tracks key press/release edges, assigns each newly pressed key to a free voice, and frees the voice when that key is released. When every voice is busy, it steals the least-recently-assigned voice. Events are serviced one at a time by a two-state FSM, so the tone bank always sees a consistent key-to-voice map.

## Interface
- `NUM_KEYS`, 48: width of the key vector; key index 0 = L-Do … 47 = 2H-Si.
- `NUM_VOICES`, 4: number of tone generators shared among all keys (2..8).
- `KEY_W`, 6: width of a key index, ceil(log2(`NUM_KEYS`)).
- `clk` input 1: single system clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `pressed_key` input `NUM_KEYS`: level vector from keyboard decoder; bit k = 1 while key k held.
- `voice_active` output `NUM_VOICES`: bit v = 1 while voice v is sounding a key.
- `voice_key` output `NUM_VOICES*KEY_W`: key index of voice v in bits [v*KEY_W +: KEY_W]; valid only when `voice_active[v]`.
- `note_on` output `NUM_VOICES`: one-cycle pulse on voice v when it is (re)assigned; envelope retrigger.
- `steal` output 1: one-cycle pulse, coincident with `note_on`, when the assignment stole an active voice.
- `busy` output 1: 1 while the FSM is in APPLY or any unserviced key edge is pending.

## Operation
- Internal `seen[NUM_KEYS]`: last key state serviced. `diff = pressed_key ^ seen`.
- A release event is key k with `seen[k]=1`, `pressed_key[k]=0`. A press event is the reverse.
- Event selection in IDLE:
  - Releases take priority over presses, so voices are freed first.
  - Within a class, the lowest key index wins.
- FSM IDLE:
  - If `diff` is nonzero, latch `ev_key`, the selected index, and `ev_press`, its type. Go to APPLY.
  - Otherwise stay in IDLE.
- FSM APPLY: executes the latched event, sets `seen[ev_key] = ev_press`, and returns to IDLE unconditionally.
  - Release: any active voice with `voice_key == ev_key` gets `voice_active` cleared. If none matches (its voice was stolen), only `seen` updates. The `age` ranks are unchanged.
  - Press, free voice exists: pick the lowest-index inactive voice v.
  - Press, no free voice: pick the voice with `age == NUM_VOICES-1` and pulse `steal`.
  - Press, in both cases: set `voice_key[v]=ev_key` and `voice_active[v]=1`, and pulse `note_on[v]`.
- LRU ranks `age[v]` in 0..`NUM_VOICES-1`, always a permutation; 0 = newest.
  - On assignment to v, every voice with `age < age[v]` increments.
  - Then `age[v]` is set to 0.
- A stolen key remains `seen=1`. Its later release changes no voice.
- The latched event is applied even if `pressed_key` changes during APPLY. The resulting mismatch appears in `diff` and is serviced next.
- A press and release of the same key, both occurring before it is selected, produce no event.

## Timing
- Reset, asynchronous:
  - `voice_active=0`, `voice_key=0`, `note_on=0`, `steal=0`, `busy=0`.
  - `seen=0`, `age[v]=v`, state IDLE.
- Reset release mid-operation: the FSM restarts in IDLE. Keys already held appear as press events, lowest index first.
- Latency:
  - `pressed_key` sampled at edge E0 in IDLE latches the event.
  - Outputs update at E1, so `note_on`/`steal` are high for the cycle following E1.
- Throughput: one event per 2 cycles. N simultaneous edges complete after 2N cycles.
- `busy` is combinational from the state and `diff`. It is high in the same cycle a new edge appears.
- `note_on`/`steal` are registered and deassert at E2. They never overlap between consecutive events.

## Test plan
- Reset with `pressed_key=0`, then press key 12:
  - 1 cycle after the sampling edge: `voice_active=0001`, `voice_key[0]=12`, `note_on=0001`, `steal=0`.
  - Release key 12: `voice_active=0000`, no `note_on`.
- Keys 3, 7, 20 asserted in the same cycle:
  - Serviced 2 cycles apart in order 3→v0, 7→v1, 20→v2.
  - `busy` is high for 6 cycles.
- Press 1, 2, 3, 4 sequentially, then 5:
  - Key 5 steals v0 (oldest): `steal=1`, `note_on=0001`, `voice_key[0]=5`.
  - Then press 6: it steals v1.
- With voices full (1..4 held), press 9 and release 2 in the same cycle:
  - The release is serviced first and frees v1.
  - 9 then takes v1 with `steal=0`.
- After the steal of key 1, release key 1: no voice change and no pulses. `busy` drops after 2 cycles.
- Assert reset mid-APPLY with keys 5 and 10 held:
  - Outputs clear immediately.
  - After release: 5→v0, then 10→v1.
